seg_reader: RTL
===============

# seg_reader

Sequential decoder for the eight-digit, active-low seven-segment bus driven by the ALU display path. On `start` it snapshots all eight digit patterns and scans them one per cycle. It then reconstructs the 4-bit two's-complement result, the overflow (`F`) flag and an error flag, and returns them over a valid/ready handshake. It sits beside the display driver as an on-board self-checker and as a scoreboard tap for benches.

## Interface
Parameters:
- `IGNORE_DP`, default 1: 1 forces the dp bit (bit 0) to "off" before decoding; 0 makes a lit dp on any digit an error.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i_seg0` … `i_seg7` input 8 each: digit patterns, active-low, bit7=a … bit1=g, bit0=dp. `i_seg0` is the ones digit, `i_seg1` is the sign position and `i_seg7` is the flag position.
- `start` input 1: request a capture and scan; honoured only in IDLE.
- `busy` output 1: high in CAPTURE and SCAN.
- `o_valid` output 1: result available; high in DONE.
- `i_ready` input 1: consumer accepts the result.
- `o_value` output 4: signed result.
- `o_flow` output 1: digit 7 showed `F`.
- `o_err` output 1: one or more decode-rule violations.

## Operation
- Pattern classes (active-low):
  - digits 0–9: 0xFC→0x03, 0x60→0x9F, 0xDA→0x25, 0xF2→0x0D, 0x66→0x99, 0xB6→0x49, 0xBE→0x41, 0xE0→0x1F, 0xFE→0x01, 0xE6→0x19 (inverted form shown).
  - MINUS: 0xFD. F: 0x71. BLANK: 0xFF.
  - Anything else is INVALID.
- Position rules:
  - pos0 must be DIGIT.
  - pos1 must be BLANK or MINUS.
  - pos2–6 must be BLANK.
  - pos7 must be BLANK or F.
  - Any violation sets the sticky `err_acc` for the current scan.
- Value:
  - Without MINUS: magnitude 0–7 is valid.
  - With MINUS: magnitude 1–8 is valid, and `o_value` = (−mag) mod 16. Magnitude 8 with MINUS gives 4'b1000.
  - Out-of-range magnitude, including "−0", sets err and forces `o_value`=0.
  - If pos0 is not a DIGIT, `o_value`=0.
- `o_flow` is 1 iff pos7 = F. It is reported even when err is set.
- FSM states:
  - IDLE: outputs are held at their previous values.
  - IDLE→CAPTURE on `start`. CAPTURE registers all eight inputs into the snapshot bank and clears the scan index, `err_acc`, the sign and the magnitude.
  - CAPTURE→SCAN unconditionally.
  - SCAN decodes snapshot[idx] each cycle. idx runs 0..7; after idx=7, SCAN→DONE.
  - DONE: `o_valid`=1 and the results are stable. DONE→IDLE when `i_ready`.
- Input changes after CAPTURE have no effect on the current result.
- `start` is ignored outside IDLE. It is not queued.

## Timing
- Reset values: state IDLE; `busy`=0, `o_valid`=0, `o_value`=0, `o_flow`=0, `o_err`=0; snapshot bank 0xFF; idx 0.
- Cycle sequence, with `start` sampled high at edge N:
  - CAPTURE is the state after edge N, and the snapshot is taken at edge N+1.
  - SCAN covers edges N+2..N+9.
  - `o_valid` rises after edge N+9. Latency is 9 cycles.
- `busy` is high after edge N through edge N+9.
- Results (`o_value`, `o_flow`, `o_err`) update at the same edge that asserts `o_valid` and hold until the next scan completes.
- Handshake:
  - Transfer occurs on an edge with `o_valid` && `i_ready`. `o_valid` drops after that edge.
  - `start` high in that same cycle is ignored; `start` is next accepted from IDLE one cycle later.
  - `i_ready` may be tied high. The minimum period between starts is then 11 cycles.
- `rst` asserted mid-scan or in DONE returns to the reset values immediately, asynchronously. No partial result is ever presented.

## Structure
- Package `seg_pkg` holds:
  - the active-low pattern constants SEG_0..SEG_9, SEG_MINUS, SEG_F, SEG_BLANK;
  - the class enum {DIGIT, MINUS, FLAG, BLANK, INVALID};
  - the state enum {IDLE, CAPTURE, SCAN, DONE}.
- Sub-module `seg_digit_decode` is combinational. It maps an 8-bit pattern plus `IGNORE_DP` to {class, digit[3:0]} and is instantiated once, muxed by idx.
- `seg_reader` holds the FSM, the snapshot bank, idx, the accumulators and the output registers.

## Test plan
- Decode +5 as ones digit 5 with the rest BLANK: `start` → `o_valid` after exactly 9 cycles with `o_value`=0x5, `o_flow`=0, `o_err`=0.
- Decode −3 as pos1 MINUS and pos0 digit 3, with pos7=F: `o_value`=0xD, `o_flow`=1, `o_err`=0. Repeat with digit 8: `o_value`=0x8, `o_err`=0.
- Errors:
  - Pos0 digit 9 with no sign gives `o_err`=1, `o_value`=0.
  - "−0" gives `o_err`=1.
  - Pos4=0x00 gives `o_err`=1.
  - Pos0 dp lit with `IGNORE_DP`=0 gives `o_err`=1.
  - With `IGNORE_DP`=1, the same dp input decodes cleanly.
- Snapshot isolation: change every `i_seg*` to 0x00 during SCAN → the result still reflects the captured pattern.
- Handshake and reset:
  - Hold `i_ready`=0 for 5 cycles → `o_valid` and the result stay stable. A `start` pulse during DONE is ignored.
  - Assert `rst` at scan cycle 4 → `busy`=0, `o_valid`=0, all outputs 0, and the next `start` completes normally in 9 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and enums for the seven-segment bus reader.
// Patterns are active-low: bit7=a .. bit1=g, bit0=dp.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h19;
  localparam logic [7:0] SEG_MINUS = 8'hFD;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {DIGIT, MINUS, FLAG, BLANK, INVALID} seg_cls_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, DONE} seg_state_t;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational classifier for one active-low seven-segment pattern.
// With IGNORE_DP set the dp bit is forced off, so a lit dp never disturbs the class.
module seg_digit_decode
  import seg_pkg::*;
#(
  parameter int IGNORE_DP = 1
) (
  input  logic [7:0] i_pat,
  output logic [2:0] o_cls,
  output logic [3:0] o_digit
);

  logic [7:0] w_pat;

  assign w_pat = (IGNORE_DP != 0) ? {i_pat[7:1], 1'b1} : i_pat;

  always_comb begin
    o_cls   = INVALID;
    o_digit = 4'd0;
    case (w_pat)
      SEG_0:     begin o_cls = DIGIT; o_digit = 4'd0; end
      SEG_1:     begin o_cls = DIGIT; o_digit = 4'd1; end
      SEG_2:     begin o_cls = DIGIT; o_digit = 4'd2; end
      SEG_3:     begin o_cls = DIGIT; o_digit = 4'd3; end
      SEG_4:     begin o_cls = DIGIT; o_digit = 4'd4; end
      SEG_5:     begin o_cls = DIGIT; o_digit = 4'd5; end
      SEG_6:     begin o_cls = DIGIT; o_digit = 4'd6; end
      SEG_7:     begin o_cls = DIGIT; o_digit = 4'd7; end
      SEG_8:     begin o_cls = DIGIT; o_digit = 4'd8; end
      SEG_9:     begin o_cls = DIGIT; o_digit = 4'd9; end
      SEG_MINUS: o_cls = MINUS;
      SEG_F:     o_cls = FLAG;
      SEG_BLANK: o_cls = BLANK;
      default:   o_cls = INVALID;
    endcase
  end

endmodule

// File: rtl/seg_reader.sv
// Snapshots the eight-digit display bus, scans one digit per cycle and
// returns the signed 4-bit value, F flag and error flag over valid/ready.
module seg_reader
  import seg_pkg::*;
#(
  parameter int IGNORE_DP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_seg0,
  input  logic [7:0] i_seg1,
  input  logic [7:0] i_seg2,
  input  logic [7:0] i_seg3,
  input  logic [7:0] i_seg4,
  input  logic [7:0] i_seg5,
  input  logic [7:0] i_seg6,
  input  logic [7:0] i_seg7,
  input  logic       start,
  output logic       busy,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [3:0] o_value,
  output logic       o_flow,
  output logic       o_err
);

  seg_state_t r_state;
  seg_state_t w_state_nxt;

  logic [7:0] r_snap [8];
  logic [2:0] r_idx;
  logic       r_err_acc;
  logic       r_neg;
  logic [3:0] r_mag;
  logic       r_dig_ok;
  logic [3:0] r_value;
  logic       r_flow;
  logic       r_err;

  logic [2:0] w_cls_raw;
  seg_cls_t   w_cls;
  logic [3:0] w_digit;
  logic       w_pos_bad;
  logic       w_err_nxt;
  logic [4:0] w_res;

  // Range check on the accumulated sign/magnitude: returns {range_err, value}.
  function automatic logic [4:0] resolve(input logic neg, input logic [3:0] mag,
                                         input logic dig_ok);
    logic in_range;
    in_range = neg ? (mag >= 4'd1 && mag <= 4'd8) : (mag <= 4'd7);
    if (!dig_ok)   return 5'b0;
    if (!in_range) return {1'b1, 4'd0};
    return {1'b0, neg ? 4'(4'd0 - mag) : mag};
  endfunction

  seg_digit_decode #(.IGNORE_DP(IGNORE_DP)) u_dec (
    .i_pat   (r_snap[r_idx]),
    .o_cls   (w_cls_raw),
    .o_digit (w_digit)
  );

  assign w_cls = seg_cls_t'(w_cls_raw);

  always_comb begin
    w_pos_bad = 1'b0;
    case (r_idx)
      3'd0:    w_pos_bad = (w_cls != DIGIT);
      3'd1:    w_pos_bad = !(w_cls == BLANK || w_cls == MINUS);
      3'd7:    w_pos_bad = !(w_cls == BLANK || w_cls == FLAG);
      default: w_pos_bad = (w_cls != BLANK);
    endcase
  end

  assign w_err_nxt = r_err_acc | w_pos_bad;
  assign w_res     = resolve(r_neg, r_mag, r_dig_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = SCAN;
      SCAN:    if (r_idx == 3'd7) w_state_nxt = DONE;
      DONE:    if (i_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) r_snap[k] <= SEG_BLANK;
      r_idx     <= 3'd0;
      r_err_acc <= 1'b0;
      r_neg     <= 1'b0;
      r_mag     <= 4'd0;
      r_dig_ok  <= 1'b0;
      r_value   <= 4'd0;
      r_flow    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        CAPTURE: begin
          r_snap[0] <= i_seg0;
          r_snap[1] <= i_seg1;
          r_snap[2] <= i_seg2;
          r_snap[3] <= i_seg3;
          r_snap[4] <= i_seg4;
          r_snap[5] <= i_seg5;
          r_snap[6] <= i_seg6;
          r_snap[7] <= i_seg7;
          r_idx     <= 3'd0;
          r_err_acc <= 1'b0;
          r_neg     <= 1'b0;
          r_mag     <= 4'd0;
          r_dig_ok  <= 1'b0;
        end
        SCAN: begin
          r_idx     <= r_idx + 3'd1;
          r_err_acc <= w_err_nxt;
          if (r_idx == 3'd0) begin
            r_mag    <= w_digit;
            r_dig_ok <= (w_cls == DIGIT);
          end
          if (r_idx == 3'd1) r_neg <= (w_cls == MINUS);
          // Last digit: publish results on the edge that raises o_valid.
          if (r_idx == 3'd7) begin
            r_value <= w_res[3:0];
            r_flow  <= (w_cls == FLAG);
            r_err   <= w_err_nxt | w_res[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == CAPTURE) || (r_state == SCAN);
  assign o_valid = (r_state == DONE);
  assign o_value = r_value;
  assign o_flow  = r_flow;
  assign o_err   = r_err;

endmodule
